muldiv_unit: RTL and testbench

Multi-cycle multiply/divide execution unit in the EX stage. It consumes the 8-bit ALU control code from the decode path and executes `EXE_MULT_OP`, `EXE_MULTU_OP`, `EXE_DIV_OP` and `EXE_DIVU_OP`. It stalls the pipeline while busy and returns a 64-bit {hi, lo} result for the HI/LO register file. All other control codes pass through without any effect.

---
 rtl/muldiv_unit.sv | 143 ++++++++++++++
 tb/tb_muldiv_unit.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit for the EX stage, producing a {hi, lo} result for HI/LO.
// Build option MULDIV_ITER_MUL_EN selects an iterative shift-add multiplier instead of a single-cycle product.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       alucontrol,
  input  logic             start,
  input  logic             flush,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [7:0] EXE_MULT_OP  = 8'b00011000;
  localparam logic [7:0] EXE_MULTU_OP = 8'b00011001;
  localparam logic [7:0] EXE_DIV_OP   = 8'b00011010;
  localparam logic [7:0] EXE_DIVU_OP  = 8'b00011011;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t           state, state_nx;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc, shreg, opnd;
  logic             neg_res, neg_rem, b_zero;

  logic             is_mul_op, is_div_op, is_signed_op, accept, last_iter;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_abs, b_abs;
  logic [WIDTH:0]   div_shift, div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] div_acc_nx, div_shreg_nx, div_q, div_r;
  logic [2*WIDTH-1:0] mul_prod, mul_res;
`ifdef MULDIV_ITER_MUL_EN
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_acc_nx, mul_shreg_nx;
`endif

  // Handshake: an op is accepted in IDLE when start=1 and flush=0; stall holds the
  // EX instruction until the DONE cycle, where done pulses with hi/lo valid and stall drops.
  always_comb begin
    is_mul_op    = (alucontrol == EXE_MULT_OP) || (alucontrol == EXE_MULTU_OP);
    is_div_op    = (alucontrol == EXE_DIV_OP)  || (alucontrol == EXE_DIVU_OP);
    is_signed_op = (alucontrol == EXE_MULT_OP) || (alucontrol == EXE_DIV_OP);
    accept       = (state == S_IDLE) && start && !flush && (is_mul_op || is_div_op);
    last_iter    = (cnt == CW'(WIDTH-1));
    stall        = accept || (((state == S_MUL) || (state == S_DIV)) && !flush);
    done         = (state == S_DONE);
    state_nx     = state;
    case (state)
      S_IDLE: if (accept) state_nx = is_div_op ? S_DIV : S_MUL;
`ifdef MULDIV_ITER_MUL_EN
      S_MUL:  if (flush) state_nx = S_IDLE; else if (last_iter) state_nx = S_DONE;
`else
      S_MUL:  state_nx = flush ? S_IDLE : S_DONE;
`endif
      S_DIV:  if (flush) state_nx = S_IDLE; else if (last_iter) state_nx = S_DONE;
      S_DONE: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    a_neg = is_signed_op && a[WIDTH-1];
    b_neg = is_signed_op && b[WIDTH-1];
    a_abs = a_neg ? ('0 - a) : a;
    b_abs = b_neg ? ('0 - b) : b;

    // Restoring step: a clear borrow bit means the trial subtraction fits.
    div_shift    = {acc, shreg[WIDTH-1]};
    div_diff     = div_shift - {1'b0, opnd};
    div_ge       = !div_diff[WIDTH];
    div_acc_nx   = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
    div_shreg_nx = {shreg[WIDTH-2:0], div_ge};
    div_q        = neg_res ? ('0 - div_shreg_nx) : div_shreg_nx;
    div_r        = neg_rem ? ('0 - div_acc_nx) : div_acc_nx;

`ifdef MULDIV_ITER_MUL_EN
    mul_sum      = {1'b0, acc} + (shreg[0] ? {1'b0, opnd} : '0);
    mul_acc_nx   = mul_sum[WIDTH:1];
    mul_shreg_nx = {mul_sum[0], shreg[WIDTH-1:1]};
    mul_prod     = {mul_acc_nx, mul_shreg_nx};
`else
    mul_prod     = {{WIDTH{1'b0}}, opnd} * {{WIDTH{1'b0}}, shreg};
`endif
    mul_res      = neg_res ? ('0 - mul_prod) : mul_prod;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      acc     <= '0;
      shreg   <= '0;
      opnd    <= '0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      b_zero  <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE: if (accept) begin
          cnt     <= '0;
          acc     <= '0;
          neg_res <= a_neg ^ b_neg;
          neg_rem <= a_neg;
          b_zero  <= (b == '0);
          shreg   <= is_div_op ? a_abs : b_abs;
          opnd    <= is_div_op ? b_abs : a_abs;
        end
        S_MUL: if (!flush) begin
`ifdef MULDIV_ITER_MUL_EN
          acc   <= mul_acc_nx;
          shreg <= mul_shreg_nx;
          cnt   <= cnt + 1'b1;
          if (last_iter) {hi, lo} <= mul_res;
`else
          {hi, lo} <= mul_res;
`endif
        end
        S_DIV: if (!flush) begin
          acc   <= div_acc_nx;
          shreg <= div_shreg_nx;
          cnt   <= cnt + 1'b1;
          // Divide by zero: remainder already equals the dividend, only the quotient is forced.
          if (last_iter) begin
            hi <= div_r;
            lo <= b_zero ? '1 : div_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed and random ops against an arithmetic reference model.
module tb_muldiv_unit;

  localparam logic [7:0] OP_MULT  = 8'b00011000;
  localparam logic [7:0] OP_MULTU = 8'b00011001;
  localparam logic [7:0] OP_DIV   = 8'b00011010;
  localparam logic [7:0] OP_DIVU  = 8'b00011011;
`ifdef MULDIV_ITER_MUL_EN
  localparam int MUL_LAT = 33;
`else
  localparam int MUL_LAT = 2;
`endif
  localparam int DIV_LAT = 33;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  alucontrol = 8'h00;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        stall, done;
  logic [31:0] hi, lo;

  int n_tests = 0;
  int n_fail = 0;
  logic [63:0] exp_q[$];
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .alucontrol(alucontrol), .start(start), .flush(flush),
    .a(a), .b(b), .stall(stall), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] model(input logic [7:0] op, input logic [31:0] av, input logic [31:0] bv);
    longint sa, sb;
    longint unsigned ua, ub;
    logic [31:0] q, r;
    sa = $signed(av);
    sb = $signed(bv);
    ua = {32'h0, av};
    ub = {32'h0, bv};
    model = '0;
    case (op)
      OP_MULT:  model = sa * sb;
      OP_MULTU: model = ua * ub;
      OP_DIV, OP_DIVU: begin
        if (bv == 32'h0) model = {av, 32'hFFFF_FFFF};
        else begin
          if (op == OP_DIV) begin q = 32'(sa / sb); r = 32'(sa % sb); end
          else              begin q = 32'(ua / ub); r = 32'(ua % ub); end
          model = {r, q};
        end
      end
      default: model = '0;
    endcase
  endfunction

  task automatic exec_op(input logic [7:0] op, input logic [31:0] av, input logic [31:0] bv);
    logic [63:0] want;
    int lat, stalls, done_cyc;
    bit got;
    exp_q.push_back(model(op, av, bv));
    lat = (op == OP_DIV || op == OP_DIVU) ? DIV_LAT : MUL_LAT;
    @(negedge clk);
    start = 1'b1; flush = 1'b0; alucontrol = op; a = av; b = bv;
    #1;
    n_tests++;
    if (hi !== exp_hi || lo !== exp_lo || done !== 1'b0) begin
      n_fail++;
      $display("FAIL hold op=%h: hi=%h lo=%h done=%b, required hi=%h lo=%h done=0", op, hi, lo, done, exp_hi, exp_lo);
    end
    stalls = 0; got = 0; done_cyc = -1;
    for (int c = 0; c <= 40 && !got; c++) begin
      if (c > 0) begin @(negedge clk); #1; end
      if (stall === 1'b1) stalls++;
      if (done === 1'b1) begin got = 1; done_cyc = c; end
    end
    n_tests++;
    if (!got) begin
      n_fail++;
      $display("FAIL timeout op=%h a=%h b=%h: no done within 40 cycles, required done at cycle %0d", op, av, bv, lat);
      exp_q.delete();
    end else begin
      want = exp_q.pop_front();
      n_tests++;
      if ({hi, lo} !== want) begin
        n_fail++;
        $display("FAIL result op=%h a=%h b=%h: got %h_%h, required %h_%h", op, av, bv, hi, lo, want[63:32], want[31:0]);
      end
      n_tests++;
      if (done_cyc != lat || stalls != lat) begin
        n_fail++;
        $display("FAIL latency op=%h: done cycle %0d stall cycles %0d, required %0d and %0d", op, done_cyc, stalls, lat, lat);
      end
      exp_hi = want[63:32];
      exp_lo = want[31:0];
    end
    @(negedge clk);
    start = 1'b0; alucontrol = 8'h00;
    #1;
    n_tests++;
    if (done !== 1'b0 || stall !== 1'b0) begin
      n_fail++;
      $display("FAIL pulse op=%h: done=%b stall=%b after DONE, required 0 0", op, done, stall);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; flush = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_tests++;
    if (hi !== 32'h0 || lo !== 32'h0 || done !== 1'b0 || stall !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: hi=%h lo=%h done=%b stall=%b, required all zero", hi, lo, done, stall);
    end
    rst = 1'b0;
    exp_hi = '0; exp_lo = '0;
  endtask

  task automatic test_directed();
    exec_op(OP_DIVU,  32'd100,       32'd7);
    exec_op(OP_DIV,   32'hFFFF_FFF9, 32'd2);
    exec_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF);
    exec_op(OP_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF);
    exec_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    exec_op(OP_DIVU,  32'h0000_1234, 32'h0);
    exec_op(OP_DIV,   32'hFFFF_FF00, 32'h0);
    exec_op(OP_MULT,  32'h8000_0000, 32'h0000_0003);
  endtask

  task automatic test_flush();
    @(negedge clk);
    start = 1'b1; alucontrol = OP_DIVU; a = 32'd1000; b = 32'd3;
    for (int c = 0; c < 10; c++) begin
      #1;
      n_tests++;
      if (done !== 1'b0 || stall !== 1'b1) begin
        n_fail++;
        $display("FAIL flush_pre cycle %0d: done=%b stall=%b, required 0 1", c, done, stall);
      end
      @(negedge clk);
    end
    flush = 1'b1;
    #1;
    n_tests++;
    if (stall !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_cycle: stall=%b done=%b, required 0 0", stall, done);
    end
    exec_op(OP_DIVU, 32'd555, 32'd10);
  endtask

  task automatic test_back_to_back();
    logic [63:0] want;
    int ndone, first, second;
    want = model(OP_DIVU, 32'd100, 32'd7);
    ndone = 0; first = -1; second = -1;
    @(negedge clk);
    start = 1'b1; alucontrol = OP_DIVU; a = 32'd100; b = 32'd7;
    for (int c = 0; c <= 72; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (done === 1'b1) begin
        ndone++;
        if (first < 0) first = c; else second = c;
        n_tests++;
        if ({hi, lo} !== want) begin
          n_fail++;
          $display("FAIL b2b_result cycle %0d: got %h_%h, required %h_%h", c, hi, lo, want[63:32], want[31:0]);
        end
      end
      if (c == 33 || c == 34) begin
        n_tests++;
        if (stall !== (c == 34)) begin
          n_fail++;
          $display("FAIL b2b_stall cycle %0d: stall=%b, required %b", c, stall, (c == 34));
        end
      end
      if (c == 67) begin start = 1'b0; alucontrol = 8'h00; end
    end
    n_tests++;
    if (ndone != 2 || first != 33 || second != 67) begin
      n_fail++;
      $display("FAIL b2b_count: %0d dones at cycles %0d/%0d, required 2 at 33/67", ndone, first, second);
    end
    exp_hi = want[63:32]; exp_lo = want[31:0];
  endtask

  task automatic test_rst_mid();
    @(negedge clk);
    start = 1'b1; alucontrol = OP_DIV; a = 32'hFFFF_FF9C; b = 32'd7;
    repeat (15) @(negedge clk);
    rst = 1'b1; start = 1'b0; alucontrol = 8'h00;
    @(negedge clk);
    #1;
    n_tests++;
    if (hi !== 32'h0 || lo !== 32'h0 || done !== 1'b0 || stall !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid: hi=%h lo=%h done=%b stall=%b, required all zero", hi, lo, done, stall);
    end
    rst = 1'b0;
    exp_hi = '0; exp_lo = '0;
  endtask

  task automatic test_random();
    logic [31:0] corner [5];
    logic [7:0] op;
    logic [31:0] av, bv;
    corner[0] = 32'h0; corner[1] = 32'h1; corner[2] = 32'h7FFF_FFFF;
    corner[3] = 32'h8000_0000; corner[4] = 32'hFFFF_FFFF;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: op = OP_MULT;
        1: op = OP_MULTU;
        2: op = OP_DIV;
        default: op = OP_DIVU;
      endcase
      case ($urandom_range(0, 3))
        0: begin av = $urandom; bv = $urandom; end
        1: begin av = $urandom_range(0, 20); bv = $urandom_range(1, 20); end
        2: begin av = $urandom; bv = 32'h0; end
        default: begin av = corner[$urandom_range(0, 4)]; bv = corner[$urandom_range(0, 4)]; end
      endcase
      exec_op(op, av, bv);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_flush();
    test_back_to_back();
    test_rst_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
